game_tick_scheduler: RTL and testbench
======================================

Name: game_tick_scheduler

Overview:
- Sequences the per-tick game-state update against the VGA frame cadence.
- Synchronises vsync from the VGA block into the clk domain and divides frames into game ticks.
- On each tick: latches nunchuck inputs, then issues one-hot step requests (player, bullet, ddavers, collision) to the game state updater, waiting on a done handshake for each.
- Sits between nunchuckDriver/vga and game_state_updater in game_runner; owns pause, fire-edge detection and overrun/timeout reporting.

Parameters:
FRAMES_PER_TICK, 4, vsync frames per game tick (>=1)
DDAVER_DIV, 8, ddaver step runs once every DDAVER_DIV ticks (>=1)
TIMEOUT_CYCLES, 65535, max clk cycles a step request may stay unacknowledged

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-low
vsync  in  1  VGA vertical sync, active-low, asynchronous to clk
stick_y  in  8  nunchuck joystick Y
z  in  1  nunchuck Z button (fire)
c  in  1  nunchuck C button (pause toggle)
bullet_active  in  1  a bullet is in flight
step_done  in  1  updater finished the current step (1-cycle pulse)
step_req  out  4  one-hot step request: [0] player, [1] bullet, [2] ddavers, [3] collide
stick_y_q  out  8  stick_y captured at tick start
fire  out  1  z rising edge captured for this tick; held until tick end
paused  out  1  pause state
busy  out  1  tick sequence in progress
overrun  out  1  sticky: tick became due while busy
timeout  out  1  sticky: a step exceeded TIMEOUT_CYCLES
tick_count  out  16  completed ticks, wraps at 65535->0

Behaviour:
- Reset (rst=0 at clk edge): all outputs 0, state IDLE, frame and ddaver counters 0, sync flops 1, z/c edge registers 0.
- vsync passes through a 2-flop synchroniser. A falling edge of the synchronised signal gives frame_pulse, 1 cycle, 3 clk cycles after the vsync fall.
- Frame counter:
  - Increments on frame_pulse when not paused; on reaching FRAMES_PER_TICK-1 it wraps to 0 and asserts tick_due for 1 cycle.
  - Holds while paused.
- Pause:
  - A c rising edge (sampled on frame_pulse only, debounced to frame rate) toggles paused.
  - A pause toggle during a tick takes effect after the tick completes; the current tick always finishes.
- tick_due while busy: tick dropped, overrun<=1 (cleared only by reset).
- FSM states: IDLE, LATCH, PLAYER, BULLET, DDAVER, COLLIDE, FINISH.
  - IDLE: tick_due & !paused -> LATCH; busy<=1.
  - LATCH (1 cycle):
    - stick_y_q<=stick_y.
    - fire<=z & !z_prev_tick. z_prev_tick<=z.
    - -> PLAYER.
  - PLAYER: step_req=0001 -> BULLET on step_done.
  - BULLET:
    - If bullet_active|fire was sampled at LATCH: step_req=0010 until step_done.
    - Otherwise skipped with 0 cycles of request (next state taken directly from PLAYER's done cycle).
    - -> DDAVER.
  - DDAVER: runs only when ddaver counter==DDAVER_DIV-1, else skipped. The ddaver counter advances once per tick in FINISH. -> COLLIDE.
  - COLLIDE: step_req=0100... corrected: COLLIDE step_req=1000; DDAVER step_req=0100. -> FINISH on step_done.
  - FINISH (1 cycle): tick_count++, fire<=0, busy<=0 -> IDLE.
- step_req is registered, exactly one bit high in step states. It deasserts the cycle after step_done is sampled, and the next step_req asserts in that same cycle (no gap).
- step_done outside a step state is ignored. step_done coinciding with the cycle the request is first raised counts as done.
- Timeout: per-step cycle counter reset on entering each step state. At TIMEOUT_CYCLES without step_done: timeout<=1, step abandoned, advance as if done.
- Reset mid-tick: immediate return to reset values; step_req drops in the reset cycle.

Decomposition:
- Shared package game_pkg:
  - step index constants STEP_PLAYER=0, STEP_BULLET=1, STEP_DDAVER=2, STEP_COLLIDE=3
  - state enum tick_state_t
  - STEP_W=4
- One sub-module: frame_sync_div (2-flop synchroniser, edge detect, frame counter with hold) produces frame_pulse/tick_due. The FSM stays in game_tick_scheduler.

Test Plan:
- Reset, FRAMES_PER_TICK=4, 4 vsync falls, step_done pulsed 2 cycles after each request; bullet_active=0, z=0 -> step_req sequence 0001, 1000 only; tick_count=1; busy low after FINISH.
- z 0->1 before tick, stick_y=8'hA5 -> stick_y_q=A5, fire=1 through tick, step_req 0001,0010,1000; next tick with z held 1 -> fire=0, bullet step skipped.
- DDAVER_DIV=8, run 16 ticks -> step_req 0100 issued on ticks 8 and 16 only.
- Withhold step_done past FRAMES_PER_TICK frames -> overrun=1, extra tick dropped; with TIMEOUT_CYCLES=100 and no done -> timeout=1 after 100 cycles, sequence advances.
- c rising at frame boundary -> paused=1, no step_req across 12 frames, tick_count unchanged; second c edge -> paused=0, ticks resume.
- rst=0 asserted while step_req=0010 -> next edge all outputs 0, state IDLE; tick_count=0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared step indices, FSM state type and request decode for the game tick scheduler.
package game_pkg;

    localparam int unsigned STEP_W       = 4;
    localparam int unsigned STEP_PLAYER  = 0;
    localparam int unsigned STEP_BULLET  = 1;
    localparam int unsigned STEP_DDAVER  = 2;
    localparam int unsigned STEP_COLLIDE = 3;

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StPlayer,
        StBullet,
        StDdaver,
        StCollide,
        StFinish
    } tick_state_t;

    function automatic logic [STEP_W-1:0] step_onehot(input tick_state_t st);
        logic [STEP_W-1:0] req;
        req = '0;
        case (st)
            StPlayer:  req[STEP_PLAYER]  = 1'b1;
            StBullet:  req[STEP_BULLET]  = 1'b1;
            StDdaver:  req[STEP_DDAVER]  = 1'b1;
            StCollide: req[STEP_COLLIDE] = 1'b1;
            default:   req = '0;
        endcase
        return req;
    endfunction

endpackage

// File: rtl/frame_sync_div.sv
// Synchronises vsync into clk, detects its falling edge and divides frames into tick_due pulses.
module frame_sync_div #(
    parameter int unsigned FRAMES_PER_TICK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    input  logic hold,
    output logic frame_pulse,
    output logic tick_due
);

    localparam int unsigned CW = (FRAMES_PER_TICK > 1) ? $clog2(FRAMES_PER_TICK) : 1;
    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAMES_PER_TICK - 1);

    // [0],[1] form the synchroniser, [2] is the history bit for edge detection.
    logic [2:0]    sync_q;
    logic [CW-1:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q      <= '1;
            frame_cnt_q <= '0;
            frame_pulse <= 1'b0;
            tick_due    <= 1'b0;
        end else begin
            sync_q      <= {sync_q[1:0], vsync};
            frame_pulse <= sync_q[2] & ~sync_q[1];
            tick_due    <= 1'b0;
            if (frame_pulse && !hold) begin
                if (frame_cnt_q == FRAME_LAST) begin
                    frame_cnt_q <= '0;
                    tick_due    <= 1'b1;
                end else begin
                    frame_cnt_q <= frame_cnt_q + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/game_tick_scheduler.sv
// Per-tick sequencer: latches nunchuck inputs and walks the updater through its steps,
// handling pause, fire-edge detection, overrun and step timeouts.
module game_tick_scheduler
    import game_pkg::*;
#(
    parameter int unsigned FRAMES_PER_TICK = 4,
    parameter int unsigned DDAVER_DIV      = 8,
    parameter int unsigned TIMEOUT_CYCLES  = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vsync,
    input  logic [7:0]        stick_y,
    input  logic              z,
    input  logic              c,
    input  logic              bullet_active,
    input  logic              step_done,
    output logic [STEP_W-1:0] step_req,
    output logic [7:0]        stick_y_q,
    output logic              fire,
    output logic              paused,
    output logic              busy,
    output logic              overrun,
    output logic              timeout,
    output logic [15:0]       tick_count
);

    localparam int unsigned DW = (DDAVER_DIV > 1) ? $clog2(DDAVER_DIV) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DW-1:0] DDAVER_LAST  = DW'(DDAVER_DIV - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    tick_state_t   state_q, state_d;
    logic          frame_pulse, tick_due;
    logic          c_prev_q, pause_pend_q, z_prev_q, bullet_run_q;
    logic [DW-1:0] ddaver_cnt_q;
    logic [TW-1:0] step_cnt_q;
    logic          in_step, step_expired, step_adv, ddaver_run, fire_new, pause_edge;

    frame_sync_div #(
        .FRAMES_PER_TICK(FRAMES_PER_TICK)
    ) u_frame_sync_div (
        .clk        (clk),
        .rst        (rst),
        .vsync      (vsync),
        .hold       (paused),
        .frame_pulse(frame_pulse),
        .tick_due   (tick_due)
    );

    always_comb begin
        state_d      = state_q;
        in_step      = (state_q == StPlayer) || (state_q == StBullet) ||
                       (state_q == StDdaver) || (state_q == StCollide);
        step_expired = in_step && (step_cnt_q == TIMEOUT_LAST);
        step_adv     = in_step && (step_done || step_expired);
        ddaver_run   = (ddaver_cnt_q == DDAVER_LAST);
        fire_new     = z & ~z_prev_q;
        pause_edge   = frame_pulse & c & ~c_prev_q;

        case (state_q)
            StIdle:    if (tick_due && !paused) state_d = StLatch;
            StLatch:   state_d = StPlayer;
            // Skipped steps are bypassed directly from the previous step's done cycle.
            StPlayer: begin
                if (step_adv) begin
                    if (bullet_run_q)    state_d = StBullet;
                    else if (ddaver_run) state_d = StDdaver;
                    else                 state_d = StCollide;
                end
            end
            StBullet:  if (step_adv) state_d = ddaver_run ? StDdaver : StCollide;
            StDdaver:  if (step_adv) state_d = StCollide;
            StCollide: if (step_adv) state_d = StFinish;
            StFinish:  state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            step_req     <= '0;
            stick_y_q    <= '0;
            fire         <= 1'b0;
            paused       <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            timeout      <= 1'b0;
            tick_count   <= '0;
            c_prev_q     <= 1'b0;
            pause_pend_q <= 1'b0;
            z_prev_q     <= 1'b0;
            bullet_run_q <= 1'b0;
            ddaver_cnt_q <= '0;
            step_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            step_req   <= step_onehot(state_d);
            busy       <= (state_d != StIdle);
            step_cnt_q <= (in_step && !step_adv) ? step_cnt_q + TW'(1) : '0;

            if (tick_due && state_q != StIdle) overrun <= 1'b1;
            if (step_expired && !step_done)    timeout <= 1'b1;
            if (frame_pulse)                   c_prev_q <= c;

            // Toggles seen mid-tick are parked and applied once the tick finishes.
            if (state_q == StIdle) begin
                if (pause_edge) paused <= ~paused;
            end else if (state_q == StFinish) begin
                paused       <= paused ^ pause_pend_q ^ pause_edge;
                pause_pend_q <= 1'b0;
            end else if (pause_edge) begin
                pause_pend_q <= ~pause_pend_q;
            end

            if (state_q == StLatch) begin
                stick_y_q    <= stick_y;
                fire         <= fire_new;
                z_prev_q     <= z;
                bullet_run_q <= bullet_active | fire_new;
            end

            if (state_q == StFinish) begin
                tick_count   <= tick_count + 16'd1;
                fire         <= 1'b0;
                ddaver_cnt_q <= ddaver_run ? '0 : ddaver_cnt_q + DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Self-checking bench: frame-level reference model of tick cadence, pause and step ordering.
module tb_game_tick_scheduler;

    localparam int unsigned FPT        = 4;
    localparam int unsigned DIV        = 8;
    localparam int unsigned TMO        = 100;
    localparam int          FRAME_HIGH = 28;

    logic        clk = 1'b0;
    logic        rst;
    logic        vsync;
    logic [7:0]  stick_y;
    logic        z;
    logic        c;
    logic        bullet_active;
    logic        step_done;
    logic [3:0]  step_req;
    logic [7:0]  stick_y_q;
    logic        fire;
    logic        paused;
    logic        busy;
    logic        overrun;
    logic        timeout;
    logic [15:0] tick_count;

    always #5 clk = ~clk;

    game_tick_scheduler #(
        .FRAMES_PER_TICK(FPT),
        .DDAVER_DIV     (DIV),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .vsync        (vsync),
        .stick_y      (stick_y),
        .z            (z),
        .c            (c),
        .bullet_active(bullet_active),
        .step_done    (step_done),
        .step_req     (step_req),
        .stick_y_q    (stick_y_q),
        .fire         (fire),
        .paused       (paused),
        .busy         (busy),
        .overrun      (overrun),
        .timeout      (timeout),
        .tick_count   (tick_count)
    );

    int checks   = 0;
    int failures = 0;

    // Updater stand-in: answers each request after rsp_delay cycles (0 = same cycle).
    logic       respond_en = 1'b1;
    logic       rsp_rand   = 1'b0;
    logic [3:0] rsp_last   = 4'b0;
    int         rsp_age    = 0;
    int         rsp_delay  = 1;

    always @(negedge clk) begin
        if (step_req != 4'b0 && step_req == rsp_last) begin
            rsp_age++;
        end else begin
            rsp_age   = 0;
            rsp_delay = rsp_rand ? int'($urandom_range(0, 3)) : 1;
        end
        rsp_last = step_req;
        if (step_req == 4'b0) step_done = rsp_rand && ($urandom_range(0, 3) == 0);
        else                  step_done = respond_en && (rsp_age == rsp_delay);
    end

    // Request log and per-tick observations.
    logic [3:0] req_log[$];
    logic [3:0] mon_prev   = 4'b0;
    logic       fire_start = 1'b0;
    int         player_len = 0;
    logic       onehot_bad = 1'b0;

    always @(negedge clk) begin
        if (step_req != 4'b0 && step_req != mon_prev) begin
            req_log.push_back(step_req);
            if (step_req == 4'b0001) fire_start = fire;
        end
        if (step_req == 4'b0001) player_len = (mon_prev == 4'b0001) ? player_len + 1 : 1;
        if (step_req != 4'b0 && !$onehot(step_req)) onehot_bad = 1'b1;
        mon_prev = step_req;
    end

    // Reference model state.
    int   m_fc      = 0;
    int   m_ticks   = 0;
    logic m_paused  = 1'b0;
    logic m_c_prev  = 1'b0;
    logic m_z_prev  = 1'b0;
    logic m_overrun = 1'b0;
    logic m_timeout = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_frame();
        @(negedge clk);
        vsync = 1'b0;
        repeat (4) @(negedge clk);
        vsync = 1'b1;
        repeat (FRAME_HIGH) @(negedge clk);
    endtask

    task automatic model_reset();
        m_fc      = 0;
        m_ticks   = 0;
        m_paused  = 1'b0;
        m_c_prev  = 1'b0;
        m_z_prev  = 1'b0;
        m_overrun = 1'b0;
        m_timeout = 1'b0;
    endtask

    // Expected step order for one tick, compared with what the log holds from base on.
    task automatic expect_tick(input int base);
        logic        fire_exp;
        logic [15:0] exp_word;
        logic [15:0] obs_word;
        int          exp_n;
        fire_exp = z & ~m_z_prev;
        m_z_prev = z;
        exp_word = 16'h0001;
        exp_n    = 1;
        if (bullet_active || fire_exp) begin
            exp_word = {exp_word[11:0], 4'b0010};
            exp_n++;
        end
        if (m_ticks % DIV == DIV - 1) begin
            exp_word = {exp_word[11:0], 4'b0100};
            exp_n++;
        end
        exp_word = {exp_word[11:0], 4'b1000};
        exp_n++;
        m_ticks++;
        obs_word = 16'h0;
        for (int i = base; i < req_log.size(); i++) obs_word = {obs_word[11:0], req_log[i]};
        check("step_count", 32'(req_log.size() - base), 32'(exp_n));
        check("step_seq", 32'(obs_word), 32'(exp_word));
        check("tick_count", 32'(tick_count), 32'(m_ticks[15:0]));
        check("stick_y_q", 32'(stick_y_q), 32'(stick_y));
        check("fire_at_player", 32'(fire_start), 32'(fire_exp));
        check("fire_cleared", 32'(fire), 32'd0);
        check("busy_after_tick", 32'(busy), 32'd0);
    endtask

    task automatic run_frame(input logic cv);
        int   base;
        logic due;
        c    = cv;
        base = req_log.size();
        do_frame();
        due = 1'b0;
        if (!m_paused) begin
            m_fc++;
            if (m_fc == int'(FPT)) begin
                m_fc = 0;
                due  = 1'b1;
            end
        end
        if (cv && !m_c_prev) m_paused = ~m_paused;
        m_c_prev = cv;
        if (due) begin
            expect_tick(base);
        end else begin
            check("no_requests", 32'(req_log.size() - base), 32'd0);
            check("tick_count_hold", 32'(tick_count), 32'(m_ticks[15:0]));
        end
        check("paused", 32'(paused), 32'(m_paused));
        check("overrun", 32'(overrun), 32'(m_overrun));
        check("timeout", 32'(timeout), 32'(m_timeout));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_step_req"}, 32'(step_req), 32'd0);
        check({tag, "_stick_y_q"}, 32'(stick_y_q), 32'd0);
        check({tag, "_fire"}, 32'(fire), 32'd0);
        check({tag, "_paused"}, 32'(paused), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
        check({tag, "_tick_count"}, 32'(tick_count), 32'd0);
    endtask

    initial begin
        int   base;
        int   waited;
        logic found;

        rst           = 1'b0;
        vsync         = 1'b1;
        stick_y       = 8'h00;
        z             = 1'b0;
        c             = 1'b0;
        bullet_active = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Plain tick: player then collide only.
        stick_y = 8'($urandom);
        for (int i = 0; i < int'(FPT); i++) run_frame(1'b0);

        // Fire edge forces the bullet step; holding z gives no second edge.
        z       = 1'b1;
        stick_y = 8'hA5;
        for (int i = 0; i < int'(FPT); i++) run_frame(1'b0);
        stick_y = 8'h5A;
        for (int i = 0; i < int'(FPT); i++) run_frame(1'b0);

        // Random inputs and updater latency across 16 ticks (ddaver ticks included).
        rsp_rand = 1'b1;
        for (int i = 0; i < 16 * int'(FPT); i++) begin
            stick_y       = 8'($urandom);
            z             = 1'($urandom);
            bullet_active = 1'($urandom);
            run_frame(1'b0);
        end
        rsp_rand      = 1'b0;
        z             = 1'b0;
        bullet_active = 1'b0;

        // Pause across 12 frames, then resume.
        run_frame(1'b1);
        for (int i = 0; i < 12; i++) run_frame(1'b0);
        run_frame(1'b1);
        for (int i = 0; i < int'(FPT); i++) run_frame(1'b0);

        // Withheld step_done: every step times out and the next due tick is dropped.
        respond_en = 1'b0;
        stick_y    = 8'h3C;
        base       = req_log.size();
        for (int i = 0; i < 2 * int'(FPT); i++) do_frame();
        waited = 0;
        while (busy && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("busy_wait_bound", 32'(busy), 32'd0);
        m_overrun = 1'b1;
        m_timeout = 1'b1;
        expect_tick(base);
        check("player_timeout_len", 32'(player_len), 32'(TMO));
        check("overrun_sticky", 32'(overrun), 32'd1);
        check("timeout_sticky", 32'(timeout), 32'd1);
        respond_en = 1'b1;

        // Reset while the bullet step is requested.
        while (m_fc != int'(FPT) - 1) run_frame(1'b0);
        bullet_active = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (i == 3) vsync = 1'b1;
            if (step_req == 4'b0010) found = 1'b1;
        end
        vsync = 1'b1;
        check("bullet_req_seen", 32'(found), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("midtick_reset");
        rst = 1'b1;
        model_reset();
        bullet_active = 1'b0;
        repeat (FRAME_HIGH) @(negedge clk);

        // After reset the fire history is clear, so z=1 is a fresh edge.
        z       = 1'b1;
        stick_y = 8'hC3;
        for (int i = 0; i < int'(FPT); i++) run_frame(1'b0);

        check("step_req_onehot", 32'(onehot_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
